// File: rtl/output_arbiter.sv
// Output-port arbiter: round-robin grant, latched-size flit sequencing, ACK/NACK retry with drop after MAX_RETRY.
// First write one cycle after eligibility; a packet waits until it fits capacity_in; ACK timeout via OUTPUT_ARBITER_TIMEOUT_EN.
module output_arbiter #(
  parameter int NUM_REQ     = 5,
  parameter int MAX_RETRY   = 3,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [3*NUM_REQ-1:0] req_size,
  input  logic [2:0]           capacity_in,
  input  logic                 ack_valid,
  input  logic                 ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic [2:0]           flit_idx,
  output logic                 write_out,
  output logic [NUM_REQ-1:0]   o_release,
  output logic                 drop_err
);
  localparam int PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW1 = PW + 1;
  localparam int RW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, RETRY} state_t;

  state_t               r_state,    w_state_nxt;
  logic [NUM_REQ-1:0]   r_grant,    w_grant_nxt;
  logic [2:0]           r_flit_idx, w_flit_idx_nxt;
  logic [NUM_REQ-1:0]   r_release,  w_release_nxt;
  logic                 r_drop_err, w_drop_err_nxt;
  logic [PW-1:0]        r_ptr,      w_ptr_nxt;
  logic [PW-1:0]        r_owner,    w_owner_nxt;
  logic [2:0]           r_size,     w_size_nxt;
  logic [RW-1:0]        r_retry,    w_retry_nxt;

  logic [NUM_REQ-1:0]   w_elig;
  logic [2*NUM_REQ-1:0] w_elig_dbl;
  logic [NUM_REQ-1:0]   w_elig_rot;
  logic                 w_found;
  logic [PW-1:0]        w_win;
  logic [2:0]           w_win_size;
  logic [PW:0]          w_sum;
  logic                 w_nack;
  logic                 w_done;
  logic                 w_timeout;

  always_comb begin
    w_elig = '0;
    for (int k = 0; k < NUM_REQ; k++)
      w_elig[k] = req[k] && (req_size[3*k +: 3] != 3'd0) && (req_size[3*k +: 3] <= capacity_in);
  end

  // Rotating by the pointer turns the round-robin search into a lowest-bit search.
  assign w_elig_dbl = {w_elig, w_elig};
  assign w_elig_rot = NUM_REQ'(w_elig_dbl >> r_ptr);

  always_comb begin
    w_found    = 1'b0;
    w_win      = '0;
    w_win_size = '0;
    w_sum      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_elig_rot[i]) begin
        w_sum = {1'b0, r_ptr} + PW1'(i);
        if (w_sum >= PW1'(NUM_REQ))
          w_sum = w_sum - PW1'(NUM_REQ);
        w_found = 1'b1;
        w_win   = w_sum[PW-1:0];
      end
    end
    for (int k = 0; k < NUM_REQ; k++)
      if (w_win == PW'(k))
        w_win_size = req_size[3*k +: 3];
  end

`ifdef OUTPUT_ARBITER_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] r_to_cnt;

  always_ff @(posedge clock) begin
    if (!reset_n || r_state != WAIT_ACK)
      r_to_cnt <= '0;
    else
      r_to_cnt <= r_to_cnt + 1'b1;
  end

  assign w_timeout = (r_state == WAIT_ACK) && !ack_valid && (r_to_cnt == TW'(ACK_TIMEOUT - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (ACK_TIMEOUT > 0);
  assign w_timeout        = 1'b0;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_flit_idx_nxt = r_flit_idx;
    w_release_nxt  = '0;
    w_drop_err_nxt = 1'b0;
    w_ptr_nxt      = r_ptr;
    w_owner_nxt    = r_owner;
    w_size_nxt     = r_size;
    w_retry_nxt    = r_retry;
    w_nack         = 1'b0;
    w_done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt    = SEND;
          w_grant_nxt    = NUM_REQ'(1) << w_win;
          w_owner_nxt    = w_win;
          w_size_nxt     = w_win_size;
          w_flit_idx_nxt = 3'd0;
          w_retry_nxt    = '0;
        end
      end
      SEND: begin
        if (r_flit_idx == r_size - 3'd1) begin
          w_state_nxt    = WAIT_ACK;
          w_flit_idx_nxt = 3'd0;
        end else begin
          w_flit_idx_nxt = r_flit_idx + 3'd1;
        end
      end
      WAIT_ACK: begin
        if (ack_valid) begin
          w_done = ack;
          w_nack = !ack;
        end else begin
          w_nack = w_timeout;
        end
        if (w_nack) begin
          if (r_retry < RW'(MAX_RETRY)) begin
            w_retry_nxt = r_retry + 1'b1;
            w_state_nxt = RETRY;
          end else begin
            w_done         = 1'b1;
            w_drop_err_nxt = 1'b1;
          end
        end
        if (w_done) begin
          w_release_nxt = r_grant;
          w_grant_nxt   = '0;
          w_ptr_nxt     = (r_owner == PW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
          w_state_nxt   = IDLE;
        end
      end
      RETRY: begin
        if (r_size <= capacity_in) begin
          w_state_nxt    = SEND;
          w_flit_idx_nxt = 3'd0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_flit_idx <= '0;
      r_release  <= '0;
      r_drop_err <= 1'b0;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_size     <= '0;
      r_retry    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_flit_idx <= w_flit_idx_nxt;
      r_release  <= w_release_nxt;
      r_drop_err <= w_drop_err_nxt;
      r_ptr      <= w_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_size     <= w_size_nxt;
      r_retry    <= w_retry_nxt;
    end
  end

  // The release strobe is named o_release because release is a reserved word.
  assign grant     = r_grant;
  assign flit_idx  = r_flit_idx;
  assign write_out = (r_state == SEND);
  assign o_release = r_release;
  assign drop_err  = r_drop_err;
endmodule

// File: tb/tb_output_arbiter.sv
// Scoreboarded bench for output_arbiter: a packet-level model queues the expected write and release events with cycle stamps.
module tb_output_arbiter;
  localparam int MAX_RETRY = 3;
  localparam int ACK_TO    = 15;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [4:0]  req;
  logic [14:0] req_size;
  logic [2:0]  capacity_in;
  logic        ack_valid;
  logic        ack;
  logic [4:0]  grant;
  logic [2:0]  flit_idx;
  logic        write_out;
  logic [4:0]  o_release;
  logic        drop_err;

  output_arbiter #(.NUM_REQ(5), .MAX_RETRY(MAX_RETRY), .ACK_TIMEOUT(ACK_TO)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_size(req_size),
    .capacity_in(capacity_in), .ack_valid(ack_valid), .ack(ack),
    .grant(grant), .flit_idx(flit_idx), .write_out(write_out),
    .o_release(o_release), .drop_err(drop_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         rel;
    int         cyc;
    logic [4:0] vec;
    logic [2:0] idx;
    logic       drop;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  bit   m_ok;
  int   cyc   = 0;
  int   m_ptr = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_tx(input int win, input int s, input int t0);
    for (int k = 0; k < s; k++)
      q.push_back('{rel: 1'b0, cyc: t0 + k, vec: 5'(1 << win), idx: 3'(k), drop: 1'b0});
  endfunction

  // Monitor: every write strobe or release/drop pulse must match the head of the queue.
  always @(negedge clock) begin
    if (write_out === 1'b1 || (|o_release) === 1'b1 || drop_err === 1'b1) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output cyc=%0d write_out=%b grant=%b flit_idx=%0d release=%b drop_err=%b",
                 cyc, write_out, grant, flit_idx, o_release, drop_err);
      end else begin
        m_e = q.pop_front();
        if (m_e.rel)
          m_ok = (write_out === 1'b0) && (o_release === m_e.vec) && (drop_err === m_e.drop) &&
                 (grant === 5'd0) && (cyc == m_e.cyc);
        else
          m_ok = (write_out === 1'b1) && (o_release === 5'd0) && (drop_err === 1'b0) &&
                 (grant === m_e.vec) && (flit_idx === m_e.idx) && (cyc == m_e.cyc);
        if (!m_ok) begin
          n_bad++;
          $display("FAIL %s: got cyc=%0d write_out=%b grant=%b flit_idx=%0d release=%b drop_err=%b; expected cyc=%0d vec=%b flit_idx=%0d drop_err=%b",
                   m_e.rel ? "release_event" : "write_event", cyc, write_out, grant, flit_idx,
                   o_release, drop_err, m_e.cyc, m_e.vec, m_e.idx, m_e.drop);
        end
      end
    end
  end

  // One packet from IDLE to its release; nacks > MAX_RETRY means the packet is dropped.
  task automatic run_pkt(input logic [4:0] rq, input logic [14:0] sz, input logic [2:0] cap,
                         input int nacks, input bit hold);
    int win, s, tx, nk, d, dip, idx;
    win = -1;
    for (int o = 0; o < 5; o++) begin
      idx = (m_ptr + o) % 5;
      if (win < 0 && rq[idx] && sz[3*idx +: 3] != 3'd0 && sz[3*idx +: 3] <= cap)
        win = idx;
    end
    req = rq; req_size = sz; capacity_in = cap; ack_valid = 1'b0; ack = 1'b0;
    if (win < 0) begin
      for (int k = 0; k < 4; k++) begin
        ack_valid = 1'($urandom); ack = 1'($urandom);
        step();
        chk("idle_no_grant", int'(grant), 0);
      end
      ack_valid = 1'b0;
      return;
    end
    s = int'(sz[3*win +: 3]);
    push_tx(win, s, cyc + 1);
    step();
    tx = 0;
    nk = 0;
    forever begin
      for (int k = 0; k < s; k++) begin
        req = 5'($urandom); req_size = 15'($urandom);
        ack_valid = 1'($urandom); ack = 1'($urandom);
        step();
      end
      ack_valid = 1'b0;
      if (hold && tx == 0 && nk == 0) begin
`ifdef OUTPUT_ARBITER_TIMEOUT_EN
        push_tx(win, s, cyc + ACK_TO + 1);
        repeat (ACK_TO + 1) step();
        tx = 1;
        continue;
`else
        repeat (100) step();
        chk("wait_ack_hold_grant", int'(grant), 1 << win);
        chk("wait_ack_hold_write", int'(write_out), 0);
`endif
      end
      d = $urandom_range(0, 3);
      repeat (d) step();
      ack_valid = 1'b1;
      ack = (nk == nacks);
      if (nk == nacks || tx == MAX_RETRY) begin
        q.push_back('{rel: 1'b1, cyc: cyc + 1, vec: 5'(1 << win), idx: 3'd0, drop: 1'(nk != nacks)});
        m_ptr = (win + 1) % 5;
        step();
        ack_valid = 1'b0;
        return;
      end
      nk++;
      tx++;
      dip = $urandom_range(0, 2);
      if (dip != 0) capacity_in = 3'(s - 1);
      step();
      ack_valid = 1'b0;
      repeat (dip) step();
      capacity_in = cap;
      push_tx(win, s, cyc + 1);
      step();
    end
  endtask

  initial begin
    logic [14:0] sz;
    int r;
    reset_n = 1'b0; req = '0; req_size = '0; capacity_in = '0; ack_valid = 1'b0; ack = 1'b0;
    repeat (3) step();
    chk("reset_grant", int'(grant), 0);
    chk("reset_flit_idx", int'(flit_idx), 0);
    chk("reset_write_out", int'(write_out), 0);
    chk("reset_release", int'(o_release), 0);
    chk("reset_drop_err", int'(drop_err), 0);
    reset_n = 1'b1;

    repeat (6) run_pkt(5'b11111, 15'b001_001_001_001_001, 3'd7, 0, 1'b0);
    run_pkt(5'b00001, 15'd3, 3'd7, 0, 1'b0);
    run_pkt(5'b00100, 15'(4 << 6), 3'd3, 0, 1'b0);
    run_pkt(5'b00100, 15'(4 << 6), 3'd4, 0, 1'b0);
    run_pkt(5'b00010, 15'(2 << 3), 3'd7, 3, 1'b0);
    run_pkt(5'b00010, 15'(2 << 3), 3'd7, 4, 1'b0);
    run_pkt(5'b01000, 15'(2 << 9), 3'd7, 0, 1'b1);

    // Reset while flit 1 is on the wire: abort with no release.
    req = 5'b00001; req_size = 15'd3; capacity_in = 3'd7;
    push_tx(m_ptr == 0 ? 0 : 0, 2, cyc + 1);
    step();
    step();
    reset_n = 1'b0;
    step();
    chk("abort_write_out", int'(write_out), 0);
    chk("abort_grant", int'(grant), 0);
    chk("abort_release", int'(o_release), 0);
    reset_n = 1'b1;
    m_ptr = 0;
    run_pkt(5'b00001, 15'd3, 3'd7, 0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      for (int k = 0; k < 5; k++) sz[3*k +: 3] = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 9);
      run_pkt(5'($urandom), sz, 3'($urandom_range(2, 7)), (r < 6) ? 0 : r - 5, 1'b0);
    end

    repeat (3) step();
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
